rv32_bram_arbiter: RTL and testbench
====================================

Name: rv32_bram_arbiter

Overview:
- Single-port controller that shares one ICE40_BRAM instance (32-bit words) between the instruction-fetch requester (IF) and the load/store requester (LSU) of the multicycle core.
- Arbitrates round-robin, sequences BRAM read latency and returns read data with a valid pulse.
- The BRAM has no byte enables, so the block implements byte-strobed writes as a read-modify-write (RMW) sequence.
- Sits between the core's fetch/LSU units and the BRAM wrapper; the BRAM is instantiated outside the block with wclk = rclk = clk.

Parameters:
- ADDR_SIZE, 8, word-address width; BRAM depth is 2**ADDR_SIZE words.
- WORD_SIZE, 32, data width; must be a multiple of 8. Strobe width SW = WORD_SIZE/8.

Ports:
- clk  in  1  single clock; also drives BRAM wclk/rclk.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with its payload until if_gnt.
- if_addr  in  ADDR_SIZE  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid (1-cycle pulse).
- if_rdata  out  WORD_SIZE  fetch read data.
- lsu_req  in  1  LSU request; held with its payload until lsu_gnt.
- lsu_we  in  1  1 = write, 0 = read.
- lsu_addr  in  ADDR_SIZE  LSU word address.
- lsu_wdata  in  WORD_SIZE  write data.
- lsu_wstrb  in  SW  byte strobes.
- lsu_gnt  out  1  LSU request accepted this cycle.
- lsu_rvalid  out  1  LSU read data valid (1-cycle pulse).
- lsu_rdata  out  WORD_SIZE  LSU read data.
- bram_wen, bram_waddr, bram_wdata  out  1/ADDR_SIZE/WORD_SIZE  BRAM write side.
- bram_ren, bram_raddr  out  1/ADDR_SIZE  BRAM read side.
- bram_rdata  in  WORD_SIZE  BRAM registered read data, valid the cycle after bram_ren.

Behaviour:
- States: IDLE, RD_RESP, RMW_WR. Reset state is IDLE.
- Reset:
  - While rst_n = 0, all outputs are 0: gnt, rvalid, bram_wen, bram_ren, addresses, wdata and rdata. Grants are gated by rst_n.
  - last_owner resets to IF, so LSU wins the first contention.
- Arbitration happens in IDLE only:
  - One requester asserted: it wins.
  - Both asserted: the requester that is not last_owner wins. last_owner updates on every grant.
  - Grant is combinational in IDLE; the winner's gnt is high for exactly one cycle.
- Read, issued in IDLE (IF always, or LSU with lsu_we = 0):
  - In the grant cycle T: gnt = 1, bram_ren = 1, bram_raddr = winner address.
  - The block latches the owner and moves to RD_RESP.
  - RD_RESP (T+1): owner rvalid = 1 and owner rdata = bram_rdata; return to IDLE.
  - Read latency is 1 cycle after grant; read throughput is one read per 2 cycles.
- Full write (lsu_we = 1, lsu_wstrb all ones): in the grant cycle, bram_wen = 1 with the address and data passed through. Stay in IDLE; no rvalid. Write throughput is one write per cycle.
- Null write (wstrb = 0): grant only, no BRAM access, stay in IDLE.
- Partial write (any other strobe value):
  - Grant cycle: bram_ren = 1 at lsu_addr; latch addr, wdata and wstrb; go to RMW_WR.
  - RMW_WR: bram_wen = 1; byte i of bram_wdata = wstrb[i] ? wdata byte i : bram_rdata byte i; return to IDLE.
  - No grants are issued while in RMW_WR.
- rdata outputs hold their last value when rvalid = 0. The non-owner's rvalid is always 0.
- Requesters must keep req and payload stable until gnt. Dropping req before gnt is legal and the request is simply not served.
- Reset asserted mid-operation: immediate return to IDLE.
  - An in-flight RD_RESP produces no rvalid.
  - A pending RMW write is dropped, leaving the memory word unchanged.
  - last_owner is reset.
- Simultaneous IF and LSU write requests: arbitration as above; the loser is served on a later IDLE cycle.

Decomposition:
- Package rv32_mem_pkg:
  - typedef enum for arb_state_t {IDLE, RD_RESP, RMW_WR};
  - typedef enum for owner_t {OWN_IF, OWN_LSU};
  - function merge_bytes(old, new, strb).
- Sub-module rv32_rr_arb2: two-input round-robin arbiter holding last_owner, with an enable input (the IDLE state). It outputs one-hot grants.

Test Plan:
- Reset with both requests high: while rst_n = 0, all gnt, bram_wen and bram_ren are 0. On the first IDLE cycle after release, lsu_gnt = 1 and if_gnt = 0.
- Preload word 0x10 = 0xDEADBEEF; IF read of 0x10 → if_gnt at T, bram_ren at T, if_rvalid = 1 with if_rdata = 0xDEADBEEF at T+1, lsu_rvalid = 0.
- LSU full write 0x12345678 to 0x20 with wstrb 4'hF → single-cycle bram_wen. A following LSU read of 0x20 returns 0x12345678.
- With word 0x20 = 0x12345678, LSU write with wstrb 4'b0010 and wdata 0x0000AB00 → read cycle then write cycle, bram_wdata = 0x1234AB78. Read-back returns 0x1234AB78.
- Both IF and LSU request reads continuously → grants alternate LSU, IF, LSU, IF every 2 cycles, with each rvalid routed only to its owner.
- Assert rst_n low during RMW_WR of a partial write to 0x20 → no bram_wen is issued; after release, a read of 0x20 still returns 0x1234AB78.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared types for the BRAM arbiter slice.
// Holds the FSM state, the owner enum and the byte-merge helper.
package rv32_mem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    RD_RESP,
    RMW_WR
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LSU
  } owner_t;

  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [WORD_W-1:0] r;
    r = old_w;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rv32_rr_arb2.sv
// Two-input round-robin arbiter (IF vs LSU), one-hot grants.
// Ports: clk, rst_n, en, req_if, req_lsu -> gnt_if, gnt_lsu.
module rv32_rr_arb2
  import rv32_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_if,
  input  logic req_lsu,
  output logic gnt_if,
  output logic gnt_lsu
);

  owner_t last_owner;

  always_comb begin
    gnt_if  = 1'b0;
    gnt_lsu = 1'b0;
    if (en) begin
      if (req_if && req_lsu) begin
        gnt_lsu = (last_owner == OWN_IF);
        gnt_if  = (last_owner == OWN_LSU);
      end else begin
        gnt_if  = req_if;
        gnt_lsu = req_lsu;
      end
    end
  end

  // Reset to IF so LSU wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_IF;
    end else if (gnt_if) begin
      last_owner <= OWN_IF;
    end else if (gnt_lsu) begin
      last_owner <= OWN_LSU;
    end
  end

endmodule

// File: rtl/rv32_bram_arbiter.sv
// Shares one single-port BRAM between fetch and LSU, with RMW for
// byte-strobed writes. Ports: if_*, lsu_* requesters; bram_* memory.
module rv32_bram_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 32,
  parameter int SW        = WORD_SIZE / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [ADDR_SIZE-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [WORD_SIZE-1:0] if_rdata,
  input  logic                 lsu_req,
  input  logic                 lsu_we,
  input  logic [ADDR_SIZE-1:0] lsu_addr,
  input  logic [WORD_SIZE-1:0] lsu_wdata,
  input  logic [SW-1:0]        lsu_wstrb,
  output logic                 lsu_gnt,
  output logic                 lsu_rvalid,
  output logic [WORD_SIZE-1:0] lsu_rdata,
  output logic                 bram_wen,
  output logic [ADDR_SIZE-1:0] bram_waddr,
  output logic [WORD_SIZE-1:0] bram_wdata,
  output logic                 bram_ren,
  output logic [ADDR_SIZE-1:0] bram_raddr,
  input  logic [WORD_SIZE-1:0] bram_rdata
);

  arb_state_t state, state_n;
  owner_t     owner_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [SW-1:0]        wstrb_q;
  logic [WORD_SIZE-1:0] if_hold, lsu_hold;
  logic gi, gl;

  rv32_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (rst_n && state == IDLE),
    .req_if  (if_req),
    .req_lsu (lsu_req),
    .gnt_if  (gi),
    .gnt_lsu (gl)
  );

  always_comb begin
    state_n    = state;
    if_gnt     = gi;
    lsu_gnt    = gl;
    if_rvalid  = 1'b0;
    lsu_rvalid = 1'b0;
    bram_wen   = 1'b0;
    bram_waddr = '0;
    bram_wdata = '0;
    bram_ren   = 1'b0;
    bram_raddr = '0;
    unique case (state)
      IDLE: begin
        if (gi) begin
          bram_ren   = 1'b1;
          bram_raddr = if_addr;
          state_n    = RD_RESP;
        end else if (gl) begin
          if (!lsu_we) begin
            bram_ren   = 1'b1;
            bram_raddr = lsu_addr;
            state_n    = RD_RESP;
          end else if (&lsu_wstrb) begin
            bram_wen   = 1'b1;
            bram_waddr = lsu_addr;
            bram_wdata = lsu_wdata;
          end else if (|lsu_wstrb) begin
            // Fetch the old word; merge happens next cycle.
            bram_ren   = 1'b1;
            bram_raddr = lsu_addr;
            state_n    = RMW_WR;
          end
        end
      end
      RD_RESP: begin
        if_rvalid  = (owner_q == OWN_IF);
        lsu_rvalid = (owner_q == OWN_LSU);
        state_n    = IDLE;
      end
      RMW_WR: begin
        bram_wen   = 1'b1;
        bram_waddr = addr_q;
        bram_wdata = merge_bytes(bram_rdata, wdata_q, wstrb_q);
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (!rst_n) begin
      if_gnt     = 1'b0;
      lsu_gnt    = 1'b0;
      if_rvalid  = 1'b0;
      lsu_rvalid = 1'b0;
      bram_wen   = 1'b0;
      bram_waddr = '0;
      bram_wdata = '0;
      bram_ren   = 1'b0;
      bram_raddr = '0;
    end
  end

  assign if_rdata  = if_rvalid  ? bram_rdata : if_hold;
  assign lsu_rdata = lsu_rvalid ? bram_rdata : lsu_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner_q  <= OWN_IF;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      if_hold  <= '0;
      lsu_hold <= '0;
    end else begin
      state <= state_n;
      if (gi) owner_q <= OWN_IF;
      if (gl) begin
        owner_q <= OWN_LSU;
        addr_q  <= lsu_addr;
        wdata_q <= lsu_wdata;
        wstrb_q <= lsu_wstrb;
      end
      if (if_rvalid)  if_hold  <= bram_rdata;
      if (lsu_rvalid) lsu_hold <= bram_rdata;
    end
  end

endmodule

// File: tb/tb_rv32_bram_arbiter.sv
// Directed bench for rv32_bram_arbiter with a behavioural BRAM.
// Inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_rv32_bram_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          lsu_req, lsu_we;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [SW-1:0] lsu_wstrb;
  logic          lsu_gnt, lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          bram_wen, bram_ren;
  logic [AW-1:0] bram_waddr, bram_raddr;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata = '0;

  logic [DW-1:0] mem [2**AW];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_wen) mem[bram_waddr] <= bram_wdata;
    if (bram_ren) bram_rdata <= mem[bram_raddr];
  end

  rv32_bram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .lsu_req    (lsu_req),
    .lsu_we     (lsu_we),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_wstrb  (lsu_wstrb),
    .lsu_gnt    (lsu_gnt),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .bram_wen   (bram_wen),
    .bram_waddr (bram_waddr),
    .bram_wdata (bram_wdata),
    .bram_ren   (bram_ren),
    .bram_raddr (bram_raddr),
    .bram_rdata (bram_rdata)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic if_read(input logic [AW-1:0] a,
                         input logic [DW-1:0] exp);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    @(negedge clk);
    check("if_gnt", 32'(if_gnt), 32'd1);
    check("if_ren", 32'(bram_ren), 32'd1);
    check("if_raddr", 32'(bram_raddr), 32'(a));
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    check("if_rvalid", 32'(if_rvalid), 32'd1);
    check("if_rdata", if_rdata, exp);
    check("if_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
  endtask

  task automatic lsu_read(input logic [AW-1:0] a,
                          input logic [DW-1:0] exp);
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = a;
    @(negedge clk);
    check("lr_gnt", 32'(lsu_gnt), 32'd1);
    check("lr_ren", 32'(bram_ren), 32'd1);
    @(posedge clk); #1;
    lsu_req = 1'b0;
    @(negedge clk);
    check("lr_rvalid", 32'(lsu_rvalid), 32'd1);
    check("lr_rdata", lsu_rdata, exp);
    check("lr_if_rvalid", 32'(if_rvalid), 32'd0);
  endtask

  task automatic lsu_wfull(input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = a;
    lsu_wdata = d; lsu_wstrb = 4'hF;
    @(negedge clk);
    check("wf_gnt", 32'(lsu_gnt), 32'd1);
    check("wf_wen", 32'(bram_wen), 32'd1);
    check("wf_waddr", 32'(bram_waddr), 32'(a));
    check("wf_wdata", bram_wdata, d);
    check("wf_ren", 32'(bram_ren), 32'd0);
    @(posedge clk); #1;
    lsu_req = 1'b0;
    @(negedge clk);
    check("wf_no_rvalid", 32'(lsu_rvalid), 32'd0);
  endtask

  task automatic lsu_wpart(input logic [AW-1:0] a,
                           input logic [DW-1:0] d,
                           input logic [SW-1:0] s,
                           input logic [DW-1:0] merged);
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = a;
    lsu_wdata = d; lsu_wstrb = s;
    @(negedge clk);
    check("wp_gnt", 32'(lsu_gnt), 32'd1);
    check("wp_ren", 32'(bram_ren), 32'd1);
    check("wp_wen0", 32'(bram_wen), 32'd0);
    @(posedge clk); #1;
    lsu_req = 1'b0;
    @(negedge clk);
    check("wp_wen1", 32'(bram_wen), 32'd1);
    check("wp_waddr", 32'(bram_waddr), 32'(a));
    check("wp_wdata", bram_wdata, merged);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 8'h05;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 8'h06;
    lsu_wdata = '0; lsu_wstrb = '0;
    repeat (2) @(negedge clk);
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_lsu_gnt", 32'(lsu_gnt), 32'd0);
    check("rst_wen", 32'(bram_wen), 32'd0);
    check("rst_ren", 32'(bram_ren), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_lsu_rdata", lsu_rdata, 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check("first_lsu_gnt", 32'(lsu_gnt), 32'd1);
    check("first_if_gnt", 32'(if_gnt), 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0; lsu_req = 1'b0;

    lsu_wfull(8'h10, 32'hDEADBEEF);
    if_read(8'h10, 32'hDEADBEEF);
    lsu_wfull(8'h20, 32'h12345678);
    lsu_read(8'h20, 32'h12345678);
    check("if_rdata_hold", if_rdata, 32'hDEADBEEF);
    lsu_wpart(8'h20, 32'h0000AB00, 4'b0010, 32'h1234AB78);
    lsu_read(8'h20, 32'h1234AB78);

    // null write: grant only
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 8'h20;
    lsu_wdata = 32'hFFFFFFFF; lsu_wstrb = 4'h0;
    @(negedge clk);
    check("null_gnt", 32'(lsu_gnt), 32'd1);
    check("null_wen", 32'(bram_wen), 32'd0);
    check("null_ren", 32'(bram_ren), 32'd0);
    @(posedge clk); #1;
    lsu_req = 1'b0;

    lsu_wfull(8'h40, 32'hAAAA0040);
    lsu_wfull(8'h41, 32'hBBBB0041);
    // leaves last_owner = IF so LSU wins next contention
    if_read(8'h41, 32'hBBBB0041);

    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 8'h41;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 8'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_lsu_gnt", 32'(lsu_gnt), 32'(i % 2 == 0));
      check("rr_if_gnt", 32'(if_gnt), 32'(i % 2 == 1));
      @(negedge clk);
      check("rr_lsu_rvalid", 32'(lsu_rvalid), 32'(i % 2 == 0));
      check("rr_if_rvalid", 32'(if_rvalid), 32'(i % 2 == 1));
      if (i % 2 == 0) check("rr_lsu_rdata", lsu_rdata, 32'hAAAA0040);
      else            check("rr_if_rdata", if_rdata, 32'hBBBB0041);
    end
    @(posedge clk); #1;
    if_req = 1'b0; lsu_req = 1'b0;

    // reset during RMW_WR drops the write
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 8'h20;
    lsu_wdata = 32'h000000FF; lsu_wstrb = 4'b0001;
    @(negedge clk);
    check("rmwr_gnt", 32'(lsu_gnt), 32'd1);
    @(posedge clk); #1;
    lsu_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rmwr_wen", 32'(bram_wen), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lsu_read(8'h20, 32'h1234AB78);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
